riscv_perf_counters: RTL and testbench

//   Parametrised performance-counter unit for the riscv core. Counts the per-cycle stat_* event

---
 rtl/riscv_perf_counters.sv | 132 +++++++++++++
 tb/tb_riscv_perf_counters.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_perf_counters.sv
// Performance-counter unit: per-event counters plus a cycle counter, with snapshot bank,
// sticky overflow, wrap/saturate mode and a timed measurement window.
module riscv_perf_counters #(
  parameter int unsigned NUM_EVT  = 12,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned SAT_MODE = 0,
  parameter int unsigned WIN_W    = 16,
  localparam int unsigned SEL_W   = $clog2(NUM_EVT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               en,
  input  logic               clr,
  input  logic               snap,
  input  logic               start,
  input  logic [WIN_W-1:0]   win_len,
  input  logic               rd_req,
  input  logic [SEL_W-1:0]   rd_sel,
  output logic [CNT_W-1:0]   rd_data,
  output logic               rd_valid,
  output logic               rd_err,
  output logic [NUM_EVT:0]   ovf,
  output logic               busy,
  output logic               done
);

  localparam int unsigned NCNT = NUM_EVT + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q    [NCNT];
  logic [CNT_W-1:0]   cnt_d    [NCNT];
  logic [CNT_W-1:0]   shadow_q [NCNT];
  logic [CNT_W-1:0]   shadow_d [NCNT];
  logic [NUM_EVT:0]   ovf_d;
  logic [WIN_W-1:0]   wcnt_q, wcnt_d;
  logic [NCNT-1:0]    hit;
  logic               start_acc;
  logic               expire;
  logic               cnt_active;
  logic [CNT_W-1:0]   rd_data_d;
  logic               rd_err_d;

  // The cycle counter sits on the top channel and is hit every active cycle.
  assign hit       = {1'b1, evt};
  assign start_acc = start && (win_len != '0);
  assign expire    = (state_q == RUN) && (wcnt_q == WIN_W'(1)) && !clr && !start_acc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clr)            state_d = IDLE;
    else if (start_acc) state_d = RUN;
    else if (expire)    state_d = DONE;
  end

  // Counter, shadow, window and read-port next values
  always_comb begin
    cnt_active = !clr && !start_acc && (((state_q == IDLE) && en) || (state_q == RUN));
    ovf_d      = ovf;
    wcnt_d     = wcnt_q;
    rd_data_d  = rd_data;
    rd_err_d   = 1'b0;
    for (int i = 0; i < NCNT; i++) begin
      cnt_d[i]    = cnt_q[i];
      shadow_d[i] = shadow_q[i];
      if (clr || start_acc) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (cnt_active && hit[i]) begin
        if (&cnt_q[i]) begin
          ovf_d[i] = 1'b1;
          cnt_d[i] = (SAT_MODE != 0) ? cnt_q[i] : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
      // Window expiry captures the final counted values, including the last cycle.
      if (expire)    shadow_d[i] = cnt_d[i];
      else if (snap) shadow_d[i] = cnt_q[i];
    end
    if (clr)                  wcnt_d = '0;
    else if (start_acc)       wcnt_d = win_len;
    else if (state_q == RUN)  wcnt_d = wcnt_q - WIN_W'(1);
    if (rd_req) begin
      if (32'(rd_sel) > NUM_EVT) begin
        rd_data_d = '0;
        rd_err_d  = 1'b1;
      end else begin
        rd_data_d = shadow_d[rd_sel];
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCNT; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
      ovf      <= '0;
      wcnt_q   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      for (int i = 0; i < NCNT; i++) begin
        cnt_q[i]    <= cnt_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      ovf      <= ovf_d;
      wcnt_q   <= wcnt_d;
      rd_data  <= rd_data_d;
      rd_valid <= rd_req;
      rd_err   <= rd_err_d;
      busy     <= (state_d == RUN);
      done     <= expire;
    end
  end

endmodule

// File: tb/tb_riscv_perf_counters.sv
// Directed bench for riscv_perf_counters: a vector table on the default build plus
// hand sequences for overflow (4-bit builds), windows, restart and async reset.
module tb_riscv_perf_counters;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] evt = '0;
  logic        en = 1'b0, clr = 1'b0, snap = 1'b0, start = 1'b0, rd_req = 1'b0;
  logic [15:0] win_len = '0;
  logic [3:0]  rd_sel = '0;

  logic [31:0] rd_data;
  logic        rd_valid, rd_err, busy, done;
  logic [12:0] ovf;
  logic [3:0]  rd_data_w, rd_data_s;
  logic        rd_valid_w, rd_err_w, busy_w, done_w;
  logic        rd_valid_s, rd_err_s, busy_s, done_s;
  logic [12:0] ovf_w, ovf_s;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  riscv_perf_counters dut (
    .clk(clk), .rst_n(rst_n), .evt(evt), .en(en), .clr(clr), .snap(snap), .start(start),
    .win_len(win_len), .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_err(rd_err), .ovf(ovf), .busy(busy), .done(done));

  riscv_perf_counters #(.CNT_W(4), .SAT_MODE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .evt(evt), .en(en), .clr(clr), .snap(snap), .start(start),
    .win_len(win_len), .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data_w),
    .rd_valid(rd_valid_w), .rd_err(rd_err_w), .ovf(ovf_w), .busy(busy_w), .done(done_w));

  riscv_perf_counters #(.CNT_W(4), .SAT_MODE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .evt(evt), .en(en), .clr(clr), .snap(snap), .start(start),
    .win_len(win_len), .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data_s),
    .rd_valid(rd_valid_s), .rd_err(rd_err_s), .ovf(ovf_s), .busy(busy_s), .done(done_s));

  typedef struct {
    logic        en;
    logic [11:0] evt;
    logic        clr, snap, start;
    logic [15:0] win;
    logic        req;
    logic [3:0]  sel;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_err, e_busy, e_done;
    logic [12:0] e_ovf;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic en_i, logic [11:0] evt_i, logic clr_i, logic snap_i,
                              logic start_i, logic [15:0] win_i, logic req_i, logic [3:0] sel_i,
                              logic v_i, logic [31:0] d_i, logic err_i);
    vec_t v;
    v.en = en_i; v.evt = evt_i; v.clr = clr_i; v.snap = snap_i; v.start = start_i;
    v.win = win_i; v.req = req_i; v.sel = sel_i;
    v.e_valid = v_i; v.e_data = d_i; v.e_err = err_i;
    v.e_busy = 1'b0; v.e_done = 1'b0; v.e_ovf = '0;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    en = 0; evt = '0; clr = 0; snap = 0; start = 0; win_len = '0; rd_req = 0; rd_sel = '0;
  endtask

  task automatic read(logic [3:0] sel);
    rd_req = 1; rd_sel = sel;
    tick();
    rd_req = 0;
  endtask

  initial begin
    int n;
    bit seen;

    // Vector table: counting, snapshot, reads, snap+clr, bad select, zero-length start.
    for (int k = 0; k < 10; k++) vq.push_back(mk(1, 12'h001, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 12'h000, 0, 1, 0, 0, 1, 0,  1, 10, 0));
    vq.push_back(mk(0, 12'h000, 0, 0, 0, 0, 1, 12, 1, 10, 0));
    vq.push_back(mk(0, 12'h000, 0, 0, 0, 0, 1, 1,  1, 0,  0));
    vq.push_back(mk(0, 12'h000, 0, 0, 0, 0, 0, 0,  0, 0,  0));
    for (int k = 0; k < 7; k++) vq.push_back(mk(1, 12'h008, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 12'h008, 1, 1, 0, 0, 0, 0,  0, 0,  0));
    vq.push_back(mk(0, 12'h000, 0, 0, 0, 0, 1, 3,  1, 7,  0));
    vq.push_back(mk(0, 12'h000, 0, 0, 0, 0, 1, 12, 1, 17, 0));
    vq.push_back(mk(0, 12'h000, 0, 1, 0, 0, 1, 3,  1, 0,  0));
    vq.push_back(mk(0, 12'h000, 0, 0, 0, 0, 1, 12, 1, 0,  0));
    vq.push_back(mk(0, 12'h000, 0, 0, 0, 0, 1, 13, 1, 0,  1));
    vq.push_back(mk(0, 12'h000, 0, 0, 0, 0, 1, 15, 1, 0,  1));
    vq.push_back(mk(1, 12'h001, 0, 0, 1, 0, 0, 0,  0, 0,  0));
    vq.push_back(mk(0, 12'h000, 0, 0, 0, 0, 0, 0,  0, 0,  0));
    vq.push_back(mk(0, 12'h000, 0, 1, 0, 0, 1, 0,  1, 1,  0));

    // Reset state
    repeat (2) tick();
    check("rst_rd_data", 64'(rd_data), 0);
    check("rst_rd_valid", 64'(rd_valid), 0);
    check("rst_ovf", 64'(ovf), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    rst_n = 1;
    tick();

    foreach (vq[k]) begin
      en = vq[k].en; evt = vq[k].evt; clr = vq[k].clr; snap = vq[k].snap;
      start = vq[k].start; win_len = vq[k].win; rd_req = vq[k].req; rd_sel = vq[k].sel;
      tick();
      check($sformatf("v%0d_valid", k), 64'(rd_valid), 64'(vq[k].e_valid));
      check($sformatf("v%0d_data", k), 64'(rd_data), 64'(vq[k].e_data));
      check($sformatf("v%0d_err", k), 64'(rd_err), 64'(vq[k].e_err));
      check($sformatf("v%0d_busy", k), 64'(busy), 64'(vq[k].e_busy));
      check($sformatf("v%0d_done", k), 64'(done), 64'(vq[k].e_done));
      check($sformatf("v%0d_ovf", k), 64'(ovf), 64'(vq[k].e_ovf));
    end
    quiet();

    // Overflow on the 4-bit builds: 17 increments -> wrap to 1 or saturate at 15.
    clr = 1; tick(); clr = 0;
    en = 1; evt = 12'h002;
    repeat (17) tick();
    en = 0; evt = '0; snap = 1;
    read(4'd1);
    snap = 0;
    check("ovf_wrap_data", 64'(rd_data_w), 1);
    check("ovf_sat_data", 64'(rd_data_s), 15);
    check("ovf_wide_data", 64'(rd_data), 17);
    check("ovf_wrap_flags", 64'(ovf_w), 64'h1002);
    check("ovf_sat_flags", 64'(ovf_s), 64'h1002);
    check("ovf_wide_flags", 64'(ovf), 0);
    read(4'd12);
    check("ovf_wrap_cyc", 64'(rd_data_w), 1);
    check("ovf_sat_cyc", 64'(rd_data_s), 15);
    clr = 1; tick(); clr = 0;
    check("ovf_wrap_clr", 64'(ovf_w), 0);
    check("ovf_sat_clr", 64'(ovf_s), 0);

    // Window of 100 cycles with evt[2] every other cycle and en low.
    start = 1; win_len = 16'd100; tick(); start = 0; win_len = '0;
    check("win_busy", 64'(busy), 1);
    check("win_done_early", 64'(done), 0);
    n = 0;
    while (!done && n < 200) begin
      evt = (n % 2 == 0) ? 12'h004 : 12'h000;
      tick();
      n++;
    end
    evt = '0;
    check("win_len_cycles", 64'(n), 100);
    check("win_busy_end", 64'(busy), 0);
    tick();
    check("win_done_pulse", 64'(done), 0);
    read(4'd2);
    check("win_evt2", 64'(rd_data), 50);
    read(4'd12);
    check("win_cyc", 64'(rd_data), 100);
    en = 1; evt = 12'hfff;
    repeat (3) tick();
    en = 0; evt = '0; snap = 1;
    read(4'd12);
    snap = 0;
    check("done_no_count", 64'(rd_data), 100);

    // Restart during RUN reloads the window and clears counters.
    start = 1; win_len = 16'd5; tick(); start = 0;
    repeat (3) tick();
    start = 1; tick(); start = 0; win_len = '0;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check("restart_cycles", 64'(n), 5);
    read(4'd12);
    check("restart_cyc", 64'(rd_data), 5);

    // Asynchronous reset in the middle of a window.
    start = 1; win_len = 16'd50; en = 1; evt = 12'hfff; tick(); start = 0; win_len = '0;
    repeat (10) tick();
    check("arst_busy_before", 64'(busy), 1);
    #2 rst_n = 0;
    #1;
    check("arst_rd_data", 64'(rd_data), 0);
    check("arst_ovf", 64'(ovf), 0);
    check("arst_busy", 64'(busy), 0);
    check("arst_done", 64'(done), 0);
    check("arst_valid_err", 64'({rd_valid, rd_err}), 0);
    quiet();
    @(posedge clk);
    #1 rst_n = 1;
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (done || busy) seen = 1;
    end
    check("arst_no_done", 64'(seen), 0);
    snap = 1;
    read(4'd12);
    snap = 0;
    check("arst_idle_cyc", 64'(rd_data), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
